// File: rtl/trigger_capture_if.sv
// Record readout channel of trigger_capture.
//   rec_valid : head record present (driven by the capture block)
//   rec_ready : consumer accepts the head record this cycle
//   rec_id    : head trigger ID
//   rec_cycle : head timestamp
// master = record producer (trigger_capture), slave = record consumer.
interface trigger_capture_if #(
    parameter int ID_WIDTH    = 16,
    parameter int CYCLE_WIDTH = 64
);
    logic                   rec_valid;
    logic                   rec_ready;
    logic [ID_WIDTH-1:0]    rec_id;
    logic [CYCLE_WIDTH-1:0] rec_cycle;

    modport master (output rec_valid, output rec_id, output rec_cycle, input rec_ready);
    modport slave  (input rec_valid, input rec_id, input rec_cycle, output rec_ready);
endinterface

// File: rtl/trigger_capture.sv
// trigger_capture: detects a rising edge on the synchronised trigger level,
// timestamps it with the reference cycle count, shifts in the serial trigger
// ID (MSB first) on the selected trigger-clock edge pulse and queues the
// completed {ID, timestamp} record in a first-word-fall-through FIFO.
//
// Ports
//   sampling_clk    sole clock
//   reset           synchronous, active-high
//   trig_in_sync    synchronised trigger level
//   trig_id_sync    synchronised serial ID data
//   clk_in_rising   one-cycle pulse on trigger clock rising edge
//   clk_in_falling  one-cycle pulse on trigger clock falling edge
//   cycle           reference cycle count
//   rec             record readout channel (trigger_capture_if.master)
//   fifo_level      number of stored records
//   interrupt       registered, high while the FIFO is non-empty
//   overflow        sticky, a completed record was dropped on a full FIFO
//   drop_count      saturating count of lost triggers
//   timeout_err     sticky capture timeout flag
//
// Optional feature: define TRIGGER_CAPTURE_TIMEOUT_EN to add a watchdog that
// aborts a capture after TIMEOUT_CYCLES clocks without an ID edge. Without
// it the capture waits indefinitely and timeout_err is tied low.
module trigger_capture #(
    parameter int ID_WIDTH       = 16,
    parameter int CYCLE_WIDTH    = 64,
    parameter int FIFO_DEPTH     = 4,
    parameter int SAMPLE_RISING  = 0,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int LEVEL_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                   sampling_clk,
    input  logic                   reset,
    input  logic                   trig_in_sync,
    input  logic                   trig_id_sync,
    input  logic                   clk_in_rising,
    input  logic                   clk_in_falling,
    input  logic [CYCLE_WIDTH-1:0] cycle,
    trigger_capture_if.master      rec,
    output logic [LEVEL_W-1:0]     fifo_level,
    output logic                   interrupt,
    output logic                   overflow,
    output logic [15:0]            drop_count,
    output logic                   timeout_err
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(ID_WIDTH + 1);

    generate
        if (ID_WIDTH < 1 || ID_WIDTH > 32) begin : g_bad_id_width
            $error("ID_WIDTH must be 1..32");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("FIFO_DEPTH must be a power of two >= 2");
        end
        if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
            $error("TIMEOUT_CYCLES must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, CAPTURE, PUSH} state_t;

    state_t                 state_reg;
    logic                   trig_prev_reg;
    logic [ID_WIDTH-1:0]    sr_reg;
    logic [CNT_W-1:0]       bit_cnt_reg;
    logic [CYCLE_WIDTH-1:0] ts_reg;

    logic [ID_WIDTH-1:0]    mem_id    [FIFO_DEPTH];
    logic [CYCLE_WIDTH-1:0] mem_cycle [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [LEVEL_W-1:0]     count_reg, count_next;
    logic [ID_WIDTH-1:0]    head_id_reg;
    logic [CYCLE_WIDTH-1:0] head_cycle_reg;
    logic                   valid_reg, irq_reg, overflow_reg;
    logic [15:0]            drop_reg, drop_next;
    logic [16:0]            drop_sum;
    logic [1:0]             drop_inc;

    logic                   trig_rise, id_edge, full, pop, push, push_drop, retrig_drop;
    logic                   load_push;
    logic [ID_WIDTH-1:0]    sr_shifted;

    assign trig_rise   = trig_in_sync & ~trig_prev_reg;
    assign id_edge     = (SAMPLE_RISING != 0) ? clk_in_rising : clk_in_falling;
    assign full        = (count_reg == LEVEL_W'(FIFO_DEPTH));
    assign pop         = valid_reg & rec.rec_ready;
    // A full FIFO still accepts the push when the head leaves in the same cycle.
    assign push        = (state_reg == PUSH) & (~full | pop);
    assign push_drop   = (state_reg == PUSH) & full & ~pop;
    assign retrig_drop = trig_rise & (state_reg != IDLE);

    generate
        if (ID_WIDTH == 1) begin : g_sr_one
            assign sr_shifted = trig_id_sync;
        end else begin : g_sr_wide
            assign sr_shifted = {sr_reg[ID_WIDTH-2:0], trig_id_sync};
        end
    endgenerate

`ifdef TRIGGER_CAPTURE_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_reg;
    logic            timeout_reg;
    logic            timeout_hit;
    assign timeout_hit = (state_reg == CAPTURE) & ~id_edge &
                         (wd_reg == WD_W'(TIMEOUT_CYCLES - 1));
    assign timeout_err = timeout_reg;
`else
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        count_next  = count_reg + LEVEL_W'(push) - LEVEL_W'(pop);
        rd_ptr_next = rd_ptr_reg + PTR_W'(pop);
        // The pushed record becomes the head when nothing else remains in front of it.
        load_push   = push & ((count_reg == '0) | ((count_reg == LEVEL_W'(1)) & pop));
        drop_inc    = 2'(retrig_drop) + 2'(push_drop);
`ifdef TRIGGER_CAPTURE_TIMEOUT_EN
        drop_inc    = drop_inc + 2'(timeout_hit);
`endif
        drop_sum    = {1'b0, drop_reg} + 17'(drop_inc);
        drop_next   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    // Capture state machine.
    always_ff @(posedge sampling_clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            trig_prev_reg <= 1'b0;
            sr_reg        <= '0;
            bit_cnt_reg   <= '0;
            ts_reg        <= '0;
`ifdef TRIGGER_CAPTURE_TIMEOUT_EN
            wd_reg        <= '0;
            timeout_reg   <= 1'b0;
`endif
        end else begin
            trig_prev_reg <= trig_in_sync;
            case (state_reg)
                IDLE: begin
                    if (trig_rise) begin
                        ts_reg      <= cycle;
                        sr_reg      <= '0;
                        bit_cnt_reg <= '0;
`ifdef TRIGGER_CAPTURE_TIMEOUT_EN
                        wd_reg      <= '0;
`endif
                        state_reg   <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (id_edge) begin
                        sr_reg      <= sr_shifted;
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
`ifdef TRIGGER_CAPTURE_TIMEOUT_EN
                        wd_reg      <= '0;
`endif
                        if (bit_cnt_reg == CNT_W'(ID_WIDTH - 1)) begin
                            state_reg <= PUSH;
                        end
                    end
`ifdef TRIGGER_CAPTURE_TIMEOUT_EN
                    else if (timeout_hit) begin
                        state_reg   <= IDLE;
                        timeout_reg <= 1'b1;
                    end else begin
                        wd_reg <= wd_reg + 1'b1;
                    end
`endif
                end
                PUSH:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Record storage: plain array with registered read into the head registers.
    always_ff @(posedge sampling_clk) begin
        if (push) begin
            mem_id[wr_ptr_reg]    <= sr_reg;
            mem_cycle[wr_ptr_reg] <= ts_reg;
        end
    end

    always_ff @(posedge sampling_clk) begin
        if (reset) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            head_id_reg    <= '0;
            head_cycle_reg <= '0;
            valid_reg      <= 1'b0;
            irq_reg        <= 1'b0;
            overflow_reg   <= 1'b0;
            drop_reg       <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            valid_reg  <= (count_next != '0);
            irq_reg    <= (count_next != '0);
            // Head registers keep their last contents once the FIFO drains.
            if (load_push) begin
                head_id_reg    <= sr_reg;
                head_cycle_reg <= ts_reg;
            end else if (pop && count_reg > LEVEL_W'(1)) begin
                head_id_reg    <= mem_id[rd_ptr_next];
                head_cycle_reg <= mem_cycle[rd_ptr_next];
            end
            if (push_drop) begin
                overflow_reg <= 1'b1;
            end
            drop_reg <= drop_next;
        end
    end

    assign rec.rec_valid = valid_reg;
    assign rec.rec_id    = head_id_reg;
    assign rec.rec_cycle = head_cycle_reg;
    assign fifo_level    = count_reg;
    assign interrupt     = irq_reg;
    assign overflow      = overflow_reg;
    assign drop_count    = drop_reg;
endmodule
